// File: rtl/f_fetch_pc.sv
// Fetch-stage PC, next-PC selection and F->D pipeline register.
// Branches and jumps resolve in D with one delay slot, so taken redirects never flush.
module f_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_TOP   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_op,
  input  logic        judge,
  input  logic [31:0] D_rsData,
  input  logic [31:0] F_instr,
  output logic [31:0] F_pc,
  output logic        F_adel,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  logic [31:0] r_pc;
  logic [31:0] r_dinstr;
  logic [31:0] r_dpc;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_npc;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_dinstr[15]}}, r_dinstr[15:0], 2'b00};

  // jr target passes through unaligned; F_adel reports it on the following fetch.
  always_comb begin
    w_npc = w_pc4;
    unique case (npc_op_e'(npc_op))
      NPC_SEQ: w_npc = w_pc4;
      NPC_BR:  w_npc = judge ? (r_dpc + 32'd4 + w_br_off) : w_pc4;
      NPC_J:   w_npc = {r_dpc[31:28], r_dinstr[25:0], 2'b00};
      NPC_JR:  w_npc = D_rsData;
      default: w_npc = w_pc4;
    endcase
  end

  // D_pc advances even on a flush so exception PCs stay traceable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_dinstr <= '0;
      r_dpc    <= RESET_PC;
    end else if (!stall) begin
      r_pc     <= w_npc;
      r_dinstr <= flush ? '0 : F_instr;
      r_dpc    <= r_pc;
    end
  end

  assign F_pc    = r_pc;
  assign F_adel  = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_TOP);
  assign D_instr = r_dinstr;
  assign D_pc    = r_dpc;
  assign D_pc8   = r_dpc + 32'd8;

endmodule

// File: tb/tb_f_fetch_pc.sv
// Directed bench for f_fetch_pc: reset, sequencing, branch/jump/jr redirects,
// stall/flush interaction, fetch-address error flag and asynchronous reset.
module tb_f_fetch_pc;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  npc_op;
  logic        judge;
  logic [31:0] D_rsData;
  logic [31:0] F_instr;
  logic [31:0] F_pc;
  logic        F_adel;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  f_fetch_pc #(
    .RESET_PC (32'h0000_3000),
    .IM_BASE  (32'h0000_3000),
    .IM_TOP   (32'h0000_6FFC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .npc_op   (npc_op),
    .judge    (judge),
    .D_rsData (D_rsData),
    .F_instr  (F_instr),
    .F_pc     (F_pc),
    .F_adel   (F_adel),
    .D_instr  (D_instr),
    .D_pc     (D_pc),
    .D_pc8    (D_pc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    npc_op   = 2'b00;
    judge    = 1'b0;
    D_rsData = '0;
    F_instr  = 32'h3C01_1234;
    #3;
    chk("rst_fpc",   F_pc,    32'h0000_3000);
    chk("rst_dinst", D_instr, 32'h0);
    chk("rst_dpc",   D_pc,    32'h0000_3000);
    chk("rst_dpc8",  D_pc8,   32'h0000_3008);
    chk("rst_adel",  {31'b0, F_adel}, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    tick;
    chk("seq1_fpc",   F_pc,    32'h0000_3004);
    chk("seq1_dinst", D_instr, 32'h3C01_1234);
    chk("seq1_dpc",   D_pc,    32'h0000_3000);
    tick;
    chk("seq2_fpc",   F_pc,    32'h0000_3008);
    chk("seq2_dpc8",  D_pc8,   32'h0000_300C);
    tick;
    chk("seq3_fpc",   F_pc,    32'h0000_300C);

    // taken branch at 3010, offset -4 words
    F_instr = 32'h0;
    tick;
    F_instr = 32'h1000_FFFC;
    tick;
    chk("br_dpc", D_pc, 32'h0000_3010);
    npc_op  = 2'b01;
    judge   = 1'b1;
    F_instr = 32'h2400_0001;
    tick;
    chk("brT_fpc",   F_pc,    32'h0000_3004);
    chk("brT_dpc",   D_pc,    32'h0000_3014);
    chk("brT_dinst", D_instr, 32'h2400_0001);

    // same branch, not taken
    npc_op  = 2'b00;
    judge   = 1'b0;
    F_instr = 32'h1000_FFFC;
    tick;
    npc_op = 2'b01;
    tick;
    chk("brN_fpc", F_pc, 32'h0000_300C);
    chk("brN_dpc", D_pc, 32'h0000_3008);

    // judge ignored when not a branch
    npc_op  = 2'b00;
    judge   = 1'b1;
    F_instr = 32'h0;
    tick;
    chk("judge_ign", F_pc, 32'h0000_3010);
    judge = 1'b0;
    repeat (4) tick;
    chk("pre_jal_fpc", F_pc, 32'h0000_3020);
    F_instr = 32'h0C00_0C10;
    tick;
    chk("jal_dpc8", D_pc8, 32'h0000_3028);
    npc_op  = 2'b10;
    F_instr = 32'h0;
    tick;
    chk("jal_fpc", F_pc, 32'h0000_3040);
    chk("jal_dpc", D_pc, 32'h0000_3024);
    npc_op   = 2'b11;
    D_rsData = 32'h0000_3028;
    tick;
    chk("jr_fpc", F_pc, 32'h0000_3028);

    // stall with taken branch in D, flush ignored while stalled
    npc_op  = 2'b00;
    F_instr = 32'h1000_FFFC;
    tick;
    chk("stpre_fpc", F_pc, 32'h0000_302C);
    npc_op  = 2'b01;
    judge   = 1'b1;
    stall   = 1'b1;
    F_instr = 32'h1111_1111;
    tick;
    chk("st1_fpc",   F_pc,    32'h0000_302C);
    chk("st1_dpc",   D_pc,    32'h0000_3028);
    chk("st1_dinst", D_instr, 32'h1000_FFFC);
    flush = 1'b1;
    tick;
    chk("st2_fpc",   F_pc,    32'h0000_302C);
    chk("st2_dpc",   D_pc,    32'h0000_3028);
    chk("st2_dinst", D_instr, 32'h1000_FFFC);
    stall = 1'b0;
    flush = 1'b0;
    tick;
    chk("strel_fpc",   F_pc,    32'h0000_301C);
    chk("strel_dinst", D_instr, 32'h1111_1111);
    npc_op = 2'b00;
    judge  = 1'b0;
    tick;
    chk("stonce_fpc", F_pc, 32'h0000_3020);

    // flush inserts a nop, PC still advances
    flush   = 1'b1;
    F_instr = 32'h2222_2222;
    tick;
    chk("fl_dinst", D_instr, 32'h0);
    chk("fl_dpc",   D_pc,    32'h0000_3020);
    chk("fl_fpc",   F_pc,    32'h0000_3024);
    flush = 1'b0;

    // fetch address error flag
    npc_op   = 2'b11;
    D_rsData = 32'h0000_3002;
    tick;
    chk("adel_mis_pc", F_pc, 32'h0000_3002);
    chk("adel_mis",    {31'b0, F_adel}, 32'h1);
    D_rsData = 32'h0000_7000;
    tick;
    chk("adel_hi", {31'b0, F_adel}, 32'h1);
    D_rsData = 32'h0000_6FFC;
    tick;
    chk("adel_top", {31'b0, F_adel}, 32'h0);
    D_rsData = 32'h0000_2FFC;
    tick;
    chk("adel_lo", {31'b0, F_adel}, 32'h1);
    D_rsData = 32'hFFFF_FFFC;
    tick;
    npc_op = 2'b00;
    tick;
    chk("wrap_fpc",  F_pc, 32'h0);
    chk("wrap_adel", {31'b0, F_adel}, 32'h1);

    // asynchronous reset mid-cycle
    D_rsData = 32'h0000_3100;
    npc_op   = 2'b11;
    tick;
    npc_op   = 2'b00;
    F_instr  = 32'h3333_3333;
    tick;
    chk("prerst_fpc", F_pc, 32'h0000_3104);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_fpc",   F_pc,    32'h0000_3000);
    chk("arst_dinst", D_instr, 32'h0);
    chk("arst_dpc",   D_pc,    32'h0000_3000);
    chk("arst_dpc8",  D_pc8,   32'h0000_3008);
    chk("arst_adel",  {31'b0, F_adel}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick;
    chk("post_fpc",   F_pc,    32'h0000_3004);
    chk("post_dinst", D_instr, 32'h3333_3333);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
